// File: rtl/ls_defines.sv
// rtl/ls_defines.sv - shared types and helpers for the load/store controller
// Package ls_defines: op and state encodings, bus widths, default I/O window,
// plus size/alignment/store-merge helpers used by dcache_ls_ctrl.

package ls_defines;

    localparam int RegBus    = 32;
    localparam int ByteWidth = 8;

    // addr[17:16] value that selects the uncached I/O window
    localparam logic [1:0] IO_BASE_HI = 2'b11;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } ls_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_READ   = 3'd2,
        ST_RWAIT  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } ls_state_e;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // access size minus one: 0 byte, 1 half, 3 word
    function automatic logic [1:0] size_m1(input logic [2:0] op);
        logic [1:0] s;
        case (op)
            OP_LB, OP_LBU, OP_SB: s = 2'd0;
            OP_LH, OP_LHU, OP_SH: s = 2'd1;
            default:              s = 2'd3;
        endcase
        return s;
    endfunction

    // force natural alignment for the access size
    function automatic logic [RegBus-1:0] align_addr(input logic [RegBus-1:0] a,
                                                     input logic [2:0]        op);
        logic [RegBus-1:0] r;
        case (size_m1(op))
            2'd3:    r = {a[RegBus-1:2], 2'b00};
            2'd1:    r = {a[RegBus-1:1], 1'b0};
            default: r = a;
        endcase
        return r;
    endfunction

    // overlay the low-aligned store bytes onto a cached word at byte offset off
    function automatic logic [RegBus-1:0] merge_store(input logic [RegBus-1:0] word,
                                                      input logic [RegBus-1:0] wdata,
                                                      input logic [1:0]        off,
                                                      input logic [1:0]        last);
        logic [RegBus-1:0] mask;
        case (last)
            2'd0:    mask = 32'h0000_00FF;
            2'd1:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/ls_extract.sv
// rtl/ls_extract.sv - byte/half select with sign or zero extension
// Ports: word (raw 32-bit word), offset (byte offset of the field),
// op (load op), result (extended 32-bit load value).

module ls_extract
    import ls_defines::*;
(
    input  logic [RegBus-1:0] word,
    input  logic [1:0]        offset,
    input  logic [2:0]        op,
    output logic [RegBus-1:0] result
);

    logic [RegBus-1:0] sel;

    always_comb begin
        sel = word >> {offset, 3'b000};
        case (op)
            OP_LB:   result = {{24{sel[7]}}, sel[7:0]};
            OP_LH:   result = {{16{sel[15]}}, sel[15:0]};
            OP_LBU:  result = {24'd0, sel[7:0]};
            OP_LHU:  result = {16'd0, sel[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dcache_ls_ctrl.sv
// rtl/dcache_ls_ctrl.sv - MEM-stage load/store controller over a byte-wide RAM with data cache
// Config macro: DCACHE_LOOKUP_EN (undefined: every access takes the uncached path,
// dc_query_en and dc_fill_en tied low).
// Ports: req_* MEM request/handshake, rsp_* completion pulse and load data,
// dc_* cache lookup (query/hit/word) and fill, mem_* byte-wide RAM bus.

module dcache_ls_ctrl
    import ls_defines::*;
#(
    parameter int         RAM_LAT    = 1,
    parameter logic [1:0] IO_BASE_HI = ls_defines::IO_BASE_HI
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [RegBus-1:0]    req_addr,
    input  logic [RegBus-1:0]    req_wdata,
    output logic                 rsp_valid,
    output logic [RegBus-1:0]    rsp_data,
    output logic                 dc_query_en,
    output logic [RegBus-1:0]    dc_query_addr,
    input  logic                 dc_hit,
    input  logic [RegBus-1:0]    dc_word,
    output logic                 dc_fill_en,
    output logic [RegBus-1:0]    dc_fill_addr,
    output logic [RegBus-1:0]    dc_fill_data,
    output logic [RegBus-1:0]    mem_a,
    output logic [ByteWidth-1:0] mem_dout,
    output logic                 mem_wr,
    input  logic [ByteWidth-1:0] mem_din
);

`ifdef DCACHE_LOOKUP_EN
    localparam bit LookupEn = 1'b1;
`else
    localparam bit LookupEn = 1'b0;
`endif

    // read data trails its address by this many READ cycles
    localparam logic [1:0] LatCnt = 2'(RAM_LAT);

    ls_state_e         state_q, state_d;
    logic [2:0]        op_q;
    logic [RegBus-1:0] addr_q;
    logic [RegBus-1:0] wdata_q;
    logic [RegBus-1:0] asm_q;
    logic [RegBus-1:0] word_q;
    logic [1:0]        cnt_q;
    logic              cached_q;
    logic              hit_q;

    logic              accept;
    logic              cacheable_in;
    logic              load_q;
    logic [1:0]        rd_last;
    logic [1:0]        wr_last;
    logic [1:0]        cap_idx;
    logic [RegBus-1:0] rd_base;
    logic [RegBus-1:0] line_addr;
    logic              fill_cond;
    logic [RegBus-1:0] ext_word;
    logic [1:0]        ext_off;
    logic [RegBus-1:0] ext_result;

    assign accept       = req_valid && (state_q == ST_IDLE);
    assign cacheable_in = LookupEn && (req_addr[17:16] != IO_BASE_HI);
    assign load_q       = !is_store(op_q);
    // a cacheable read is always a whole-line refill
    assign rd_last      = cached_q ? 2'd3 : size_m1(op_q);
    assign wr_last      = size_m1(op_q);
    assign cap_idx      = cnt_q - LatCnt;
    assign line_addr    = {addr_q[RegBus-1:2], 2'b00};
    assign rd_base      = cached_q ? line_addr : addr_q;
    // refill on a load miss, update only on a store hit (no write-allocate)
    assign fill_cond    = cached_q && (load_q ? !hit_q : hit_q);

    // hit data comes from the latched cache word, everything else from the assembly
    // register; uncached reads assemble from byte 0 so the field sits at offset 0
    assign ext_word = hit_q ? word_q : asm_q;
    assign ext_off  = cached_q ? addr_q[1:0] : 2'b00;

    ls_extract u_extract (
        .word   (ext_word),
        .offset (ext_off),
        .op     (op_q),
        .result (ext_result)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (cacheable_in)           state_d = ST_LOOKUP;
                    else if (is_store(req_op))  state_d = ST_WRITE;
                    else                        state_d = ST_READ;
                end
            end
            ST_LOOKUP: begin
                if (!load_q)     state_d = ST_WRITE;
                else if (dc_hit) state_d = ST_DONE;
                else             state_d = ST_READ;
            end
            ST_READ:  if (cnt_q == rd_last) state_d = ST_RWAIT;
            ST_RWAIT: state_d = ST_DONE;
            ST_WRITE: if (cnt_q == wr_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // request capture, byte counter and read assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            word_q   <= '0;
            cnt_q    <= 2'd0;
            cached_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req_op;
                addr_q   <= align_addr(req_addr, req_op);
                wdata_q  <= req_wdata;
                cached_q <= cacheable_in;
                hit_q    <= 1'b0;
                cnt_q    <= 2'd0;
                asm_q    <= '0;
            end
            if (state_q == ST_LOOKUP) begin
                hit_q  <= dc_hit;
                word_q <= dc_word;
            end
            if (state_q == ST_READ) begin
                if (cnt_q >= LatCnt) asm_q[{cap_idx, 3'b000} +: 8] <= mem_din;
                if (cnt_q != rd_last) cnt_q <= cnt_q + 2'd1;
            end
            // counter holds the last index here, which is the byte still in flight
            if (state_q == ST_RWAIT) begin
                asm_q[{cnt_q, 3'b000} +: 8] <= mem_din;
            end
            if (state_q == ST_WRITE) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    // outputs: all decoded from registered state so reset forces them at once
    always_comb begin
        req_ready     = (state_q == ST_IDLE);
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        dc_query_en   = 1'b0;
        dc_query_addr = '0;
        dc_fill_en    = 1'b0;
        dc_fill_addr  = '0;
        dc_fill_data  = '0;
        mem_a         = '0;
        mem_dout      = '0;
        mem_wr        = 1'b0;
        case (state_q)
            ST_LOOKUP: begin
                dc_query_en   = LookupEn;
                dc_query_addr = line_addr;
            end
            ST_READ: begin
                mem_a = rd_base + {30'd0, cnt_q};
            end
            ST_WRITE: begin
                mem_wr   = 1'b1;
                mem_a    = addr_q + {30'd0, cnt_q};
                mem_dout = wdata_q[{cnt_q, 3'b000} +: 8];
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (load_q) rsp_data = ext_result;
                if (LookupEn && fill_cond) begin
                    dc_fill_en   = 1'b1;
                    dc_fill_addr = line_addr;
                    dc_fill_data = load_q ? asm_q
                                          : merge_store(word_q, wdata_q, addr_q[1:0], wr_last);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_ls_ctrl.sv
// tb/tb_dcache_ls_ctrl.sv - randomized self-checking bench for dcache_ls_ctrl

module tb_dcache_ls_ctrl;
    import ls_defines::*;

`ifdef DCACHE_LOOKUP_EN
    localparam bit LOOKUP_EN = 1'b1;
`else
    localparam bit LOOKUP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        dc_query_en;
    logic [31:0] dc_query_addr;
    logic        dc_hit;
    logic [31:0] dc_word;
    logic        dc_fill_en;
    logic [31:0] dc_fill_addr, dc_fill_data;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        preload;

    int n_cmp = 0;
    int n_bad = 0;
    int txn_id = 0;

    always #5 clk = ~clk;

    dcache_ls_ctrl #(.RAM_LAT(1), .IO_BASE_HI(2'b11)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .dc_query_en   (dc_query_en),
        .dc_query_addr (dc_query_addr),
        .dc_hit        (dc_hit),
        .dc_word       (dc_word),
        .dc_fill_en    (dc_fill_en),
        .dc_fill_addr  (dc_fill_addr),
        .dc_fill_data  (dc_fill_data),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_wr        (mem_wr),
        .mem_din       (mem_din)
    );

    // environment: byte RAM and an untagged cache array keyed by word address
    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_ram [0:4095];
    logic        cvalid  [0:1023];
    logic [31:0] cdata   [0:1023];
    logic        ref_cv  [0:1023];

    function automatic int ridx(input logic [31:0] a);
        return int'({a[17:16], a[9:0]});
    endfunction

    function automatic int cidx(input logic [31:0] a);
        return int'({a[17:16], a[9:2]});
    endfunction

    always_comb begin
        dc_hit  = cvalid[cidx(dc_query_addr)];
        dc_word = cdata[cidx(dc_query_addr)];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) ram[i] <= ref_ram[i];
            for (int i = 0; i < 1024; i++) begin
                cvalid[i] <= 1'b0;
                cdata[i]  <= 32'd0;
            end
        end else begin
            mem_din <= ram[ridx(mem_a)];
            if (mem_wr) ram[ridx(mem_a)] <= mem_dout;
            if (dc_fill_en) begin
                cvalid[cidx(dc_fill_addr)] <= 1'b1;
                cdata[cidx(dc_fill_addr)]  <= dc_fill_data;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_ctl"}, 64'({req_ready, rsp_valid, dc_query_en, dc_fill_en, mem_wr}), 64'(5'b10000));
        check_eq({tag, "_rsp"}, 64'(rsp_data), 64'd0);
        check_eq({tag, "_qaddr"}, 64'(dc_query_addr), 64'd0);
        check_eq({tag, "_faddr"}, 64'(dc_fill_addr), 64'd0);
        check_eq({tag, "_fdata"}, 64'(dc_fill_data), 64'd0);
        check_eq({tag, "_mema"}, 64'(mem_a), 64'd0);
        check_eq({tag, "_memd"}, 64'(mem_dout), 64'd0);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_ram[ridx(a + 32'(k))];
        return w;
    endfunction

    // Starts and ends at a falling edge with the controller idle.
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got_data, output logic [31:0] got_fill);
        logic [31:0] a, rbase, w, exp_data, fill_data, ev_a;
        logic [7:0]  ev_dout;
        logic [44:0] obs, expv;
        int n, lat, rs, rn, ws;
        bit st, cached, hit, fill;

        txn_id++;
        st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        n  = (op == OP_LW || op == OP_SW) ? 4 :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        a      = addr & ~(32'(n) - 32'd1);
        cached = LOOKUP_EN && (addr[17:16] != 2'b11);
        hit    = cached && ref_cv[cidx(a)];
        w      = ref_word(a, n);
        case (op)
            OP_LB:   exp_data = {{24{w[7]}}, w[7:0]};
            OP_LH:   exp_data = {{16{w[15]}}, w[15:0]};
            OP_LBU:  exp_data = {24'd0, w[7:0]};
            OP_LHU:  exp_data = {16'd0, w[15:0]};
            OP_LW:   exp_data = w;
            default: exp_data = 32'd0;
        endcase

        rs = 0; rn = 0; ws = 0; fill = 1'b0; rbase = a; fill_data = 32'd0;
        if (!st) begin
            if (hit) begin
                lat = 2;
            end else if (cached) begin
                rs = 2; rn = 4; lat = 7; fill = 1'b1;
                rbase = {a[31:2], 2'b00};
                fill_data = ref_word(rbase, 4);
                ref_cv[cidx(a)] = 1'b1;
            end else begin
                rs = 1; rn = n; lat = n + 2;
            end
        end else begin
            ws = cached ? 2 : 1;
            lat = ws + n;
            fill = hit;
            for (int k = 0; k < n; k++) ref_ram[ridx(a + 32'(k))] = wdata[8*k +: 8];
            // write-through keeps a hit line equal to RAM
            if (hit) fill_data = ref_word({a[31:2], 2'b00}, 4);
        end

        check_eq($sformatf("idle t%0d", txn_id),
                 64'({rsp_valid, dc_fill_en, mem_wr, dc_query_en, req_ready, mem_dout, mem_a}),
                 64'({5'b00001, 8'd0, 32'd0}));
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
        got_data  = 32'd0;
        got_fill  = 32'd0;
        @(negedge clk);
        for (int c = 1; c <= lat; c++) begin
            ev_a = 32'd0; ev_dout = 8'd0;
            if (rn > 0 && c >= rs && c < rs + rn) ev_a = rbase + 32'(c - rs);
            if (st && c >= ws && c < ws + n) begin
                ev_a    = a + 32'(c - ws);
                ev_dout = wdata[8*(c - ws) +: 8];
            end
            expv = {c == lat, (c == lat) && fill, st && c >= ws && c < ws + n,
                    cached && c == 1, 1'b0, ev_dout, ev_a};
            obs  = {rsp_valid, dc_fill_en, mem_wr, dc_query_en, req_ready, mem_dout, mem_a};
            check_eq($sformatf("cyc t%0d c%0d", txn_id, c), 64'(obs), 64'(expv));
            if (c == lat) begin
                got_data = rsp_data;
                got_fill = dc_fill_data;
                check_eq($sformatf("rdata t%0d", txn_id), 64'(rsp_data), 64'(exp_data));
                if (fill) begin
                    check_eq($sformatf("faddr t%0d", txn_id), 64'(dc_fill_addr), 64'({a[31:2], 2'b00}));
                    check_eq($sformatf("fdata t%0d", txn_id), 64'(dc_fill_data), 64'(fill_data));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic abort_test();
        logic [31:0] a, d, f, exp_w;
        int rc;
        a  = 32'h0000_0120;
        rc = LOOKUP_EN ? 3 : 2;
        exp_w = ref_word(a, 4);
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = a;
        req_wdata = 32'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (rc - 1) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outs("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_quiet", 64'({req_ready, rsp_valid, dc_fill_en, mem_wr}), 64'(4'b1000));
        end
        check_eq("abort_nofill", 64'(cvalid[cidx(a)]), 64'd0);
        run_txn(OP_LW, a, 32'd0, d, f);
        check_eq("after_abort", 64'(d), 64'(exp_w));
    endtask

    initial begin
        logic [31:0] d, f, addr;
        logic [2:0]  op;
        logic [1:0]  hi;
        logic [9:0]  r;

        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        preload   = 1'b0;
        for (int i = 0; i < 4096; i++) ref_ram[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) ref_cv[i] = 1'b0;
        ref_ram[ridx(32'h104)] = 8'h11;
        ref_ram[ridx(32'h105)] = 8'h82;
        ref_ram[ridx(32'h106)] = 8'h33;
        ref_ram[ridx(32'h107)] = 8'h44;

        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check_reset_outs("por");
        rst = 1'b1;
        @(negedge clk);

        run_txn(OP_LW, 32'h0000_0104, 32'd0, d, f);
        check_eq("lw_miss", 64'(d), 64'h4433_8211);
        run_txn(OP_LB, 32'h0000_0105, 32'd0, d, f);
        check_eq("lb_hit", 64'(d), 64'hFFFF_FF82);
        run_txn(OP_LBU, 32'h0000_0105, 32'd0, d, f);
        check_eq("lbu_hit", 64'(d), 64'h0000_0082);
        run_txn(OP_SH, 32'h0000_0106, 32'h0000_ABCD, d, f);
        check_eq("sh_rsp", 64'(d), 64'd0);
        run_txn(OP_LW, 32'h0000_0104, 32'd0, d, f);
        check_eq("lw_after_sh", 64'(d), 64'hABCD_8211);
        run_txn(OP_LW, 32'h0003_0000, 32'd0, d, f);
        run_txn(OP_LW, 32'h0003_0000, 32'd0, d, f);
        run_txn(OP_SB, 32'h0003_0004, 32'h0000_005A, d, f);
        run_txn(OP_LBU, 32'h0003_0004, 32'd0, d, f);
        check_eq("io_sb_readback", 64'(d), 64'h0000_005A);

        abort_test();

        for (int t = 0; t < 400; t++) begin
            op   = 3'($urandom_range(0, 7));
            hi   = 2'($urandom_range(0, 3));
            r    = 10'($urandom_range(32'h100, 32'h13F));
            addr = {14'd0, hi, 6'd0, r};
            run_txn(op, addr, $urandom, d, f);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
